// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read channel between fetch_ctrl (master) and the memory slave.
interface fetch_ctrl_if #(
  parameter int BITWIDTH = 32
);
  logic [BITWIDTH-1:0] araddr;
  logic                arvalid;
  logic                arready;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/fetch_ctrl.sv
// PC/fetch sequencer: one instruction in flight, 4 cycles per instruction at best.
// Each handshake stage holds its outputs stable until the partner accepts; faults halt fetch until reset.
module fetch_ctrl #(
  parameter int                  BITWIDTH  = 32,
  parameter logic [BITWIDTH-1:0] RST_VALUE = BITWIDTH'(32'h8000_0000)
) (
  input  logic                clk,
  input  logic                rst,
  fetch_ctrl_if.master        bus,
  output logic [31:0]         inst,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic                commit_valid,
  input  logic [1:0]          pc_sel,
  input  logic [BITWIDTH-1:0] rs1_data,
  input  logic [31:0]         imm,
  output logic [BITWIDTH-1:0] pc,
  output logic                fetch_err,
  output logic [1:0]          err_cause,
  output logic [31:0]         retired
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AR    = 3'd1,
    R     = 3'd2,
    ISSUE = 3'd3,
    EXEC  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_BUS   = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;

  state_t              state;
  logic                started;
  logic                arvalid_q;
  logic                rready_q;
  logic [BITWIDTH-1:0] op_a;
  logic [BITWIDTH-1:0] op_b;
  logic [BITWIDTH-1:0] next_pc;

  assign bus.araddr  = pc;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  always_comb begin
    op_a    = pc_sel[1] ? rs1_data : pc;
    op_b    = pc_sel[0] ? BITWIDTH'(imm) : BITWIDTH'(4);
    next_pc = op_a + op_b;
    // JALR target has bit 0 cleared before the alignment check
    if (pc_sel == 2'b11) begin
      next_pc[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      started    <= 1'b0;
      pc         <= RST_VALUE;
      inst       <= '0;
      retired    <= '0;
      fetch_err  <= 1'b0;
      err_cause  <= 2'b00;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // one full post-reset cycle in IDLE before the first request
          if (!started) begin
            started <= 1'b1;
          end else begin
            state     <= AR;
            arvalid_q <= 1'b1;
          end
        end
        AR: begin
          if (bus.arready) begin
            state     <= R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        R: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            if (bus.rresp == 2'b00) begin
              inst       <= bus.rdata;
              inst_valid <= 1'b1;
              state      <= ISSUE;
            end else begin
              fetch_err <= 1'b1;
              err_cause <= CAUSE_BUS;
              state     <= ERROR;
            end
          end
        end
        ISSUE: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (commit_valid) begin
            retired <= retired + 32'd1;
            if (next_pc[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              err_cause <= CAUSE_ALIGN;
              state     <= ERROR;
            end else begin
              pc        <= next_pc;
              arvalid_q <= 1'b1;
              state     <= AR;
            end
          end
        end
        ERROR: begin
          arvalid_q  <= 1'b0;
          rready_q   <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: begin
          state <= ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with hand-computed expected values.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        commit_valid;
  logic [1:0]  pc_sel;
  logic [31:0] rs1_data;
  logic [31:0] imm;
  logic [31:0] pc;
  logic        fetch_err;
  logic [1:0]  err_cause;
  logic [31:0] retired;

  int tests = 0;
  int fails = 0;

  fetch_ctrl_if #(.BITWIDTH(32)) bus ();

  fetch_ctrl #(.BITWIDTH(32), .RST_VALUE(32'h8000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .commit_valid (commit_valid),
    .pc_sel       (pc_sel),
    .rs1_data     (rs1_data),
    .imm          (imm),
    .pc           (pc),
    .fetch_err    (fetch_err),
    .err_cause    (err_cause),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; inst_ready = 1'b0; commit_valid = 1'b0;
    pc_sel = 2'b00; rs1_data = '0; imm = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
    tick(2);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_err", {29'd0, fetch_err, err_cause}, 32'h0);
    chk("rst_valids", {29'd0, bus.arvalid, bus.rready, inst_valid}, 32'h0);

    // reset fetch with zero-wait slave
    rst = 1'b1; bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0013;
    tick(1);
    chk("c1_arvalid", {31'd0, bus.arvalid}, 32'h0);
    tick(1);
    chk("c2_arvalid", {31'd0, bus.arvalid}, 32'h1);
    chk("c2_araddr", bus.araddr, 32'h8000_0000);
    tick(1);
    chk("c3_rready", {31'd0, bus.rready}, 32'h1);
    tick(1);
    chk("c4_inst_valid", {31'd0, inst_valid}, 32'h1);
    chk("c4_inst", inst, 32'h0000_0013);

    // sequential, branch-back and JALR commits
    inst_ready = 1'b1; commit_valid = 1'b1; pc_sel = 2'b00;
    tick(1);
    chk("c5_inst_valid", {31'd0, inst_valid}, 32'h0);
    tick(1);
    chk("seq_pc", pc, 32'h8000_0004);
    chk("seq_retired", retired, 32'd1);
    chk("seq_arvalid", {31'd0, bus.arvalid}, 32'h1);
    pc_sel = 2'b01; imm = 32'hFFFF_FFFC;
    tick(4);
    chk("br_pc", pc, 32'h8000_0000);
    chk("br_retired", retired, 32'd2);
    pc_sel = 2'b11; rs1_data = 32'h8000_1001; imm = 32'h0;
    tick(4);
    chk("jalr_pc", pc, 32'h8000_1000);
    chk("jalr_araddr", bus.araddr, 32'h8000_1000);
    chk("jalr_retired", retired, 32'd3);

    // arready stall with a stray commit pulse in AR
    bus.arready = 1'b0; bus.rvalid = 1'b0; pc_sel = 2'b01; imm = 32'h8;
    tick(1);
    chk("stray_pc", pc, 32'h8000_1000);
    chk("stray_retired", retired, 32'd3);
    commit_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick(1);
      chk("ar_stall_arvalid", {31'd0, bus.arvalid}, 32'h1);
      chk("ar_stall_araddr", bus.araddr, 32'h8000_1000);
    end
    bus.arready = 1'b1; bus.rdata = 32'h0010_0093;
    tick(1);
    chk("r_entry_arvalid", {31'd0, bus.arvalid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("r_stall_rready", {31'd0, bus.rready}, 32'h1);
      tick(1);
    end
    chk("r_stall_rready_last", {31'd0, bus.rready}, 32'h1);
    bus.rvalid = 1'b1; inst_ready = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      chk("issue_stall_inst", inst, 32'h0010_0093);
      chk("issue_stall_valid", {31'd0, inst_valid}, 32'h1);
      if (i < 2) tick(1);
    end
    inst_ready = 1'b1;
    tick(1);
    chk("exec_inst_valid", {31'd0, inst_valid}, 32'h0);

    // misaligned JALR target
    commit_valid = 1'b1; pc_sel = 2'b11; rs1_data = 32'h8000_1002; imm = 32'h0;
    tick(1);
    commit_valid = 1'b0;
    chk("mis_fetch_err", {31'd0, fetch_err}, 32'h1);
    chk("mis_cause", {30'd0, err_cause}, 32'h2);
    chk("mis_pc", pc, 32'h8000_1000);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("mis_halt_valids", {29'd0, bus.arvalid, bus.rready, inst_valid}, 32'h0);
    end

    // bus error after one good instruction
    rst = 1'b0;
    tick(1);
    rst = 1'b1; bus.rresp = 2'b00; bus.rdata = 32'h0000_0013;
    chk("rst2_err", {29'd0, fetch_err, err_cause}, 32'h0);
    chk("rst2_pc", pc, 32'h8000_0000);
    tick(2);
    chk("restart_arvalid", {31'd0, bus.arvalid}, 32'h1);
    chk("restart_araddr", bus.araddr, 32'h8000_0000);
    tick(3);
    commit_valid = 1'b1; pc_sel = 2'b00; bus.rresp = 2'b10; bus.rdata = 32'hDEAD_BEEF;
    tick(1);
    commit_valid = 1'b0;
    chk("be_pc", pc, 32'h8000_0004);
    tick(2);
    chk("be_fetch_err", {31'd0, fetch_err}, 32'h1);
    chk("be_cause", {30'd0, err_cause}, 32'h1);
    chk("be_inst", inst, 32'h0000_0013);
    chk("be_inst_valid", {31'd0, inst_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("be_halt_arvalid", {31'd0, bus.arvalid}, 32'h0);
      chk("be_sticky", {31'd0, fetch_err}, 32'h1);
    end

    // reset while in R
    rst = 1'b0;
    tick(1);
    rst = 1'b1; bus.rresp = 2'b00; bus.rvalid = 1'b0;
    tick(2);
    chk("mid_araddr", bus.araddr, 32'h8000_0000);
    tick(1);
    chk("mid_rready", {31'd0, bus.rready}, 32'h1);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_valids", {29'd0, bus.arvalid, bus.rready, inst_valid}, 32'h0);
    chk("mid_rst_pc", pc, 32'h8000_0000);

    // reset beats a simultaneous commit
    rst = 1'b1; bus.rvalid = 1'b1; commit_valid = 1'b1; pc_sel = 2'b00;
    tick(6);
    chk("pre_pc", pc, 32'h8000_0004);
    chk("pre_retired", retired, 32'd1);
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rc_pc", pc, 32'h8000_0000);
    chk("rc_retired", retired, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the program counter and instruction fetch path of the NPC core. Owns the PC register and next-PC adder, issues one instruction-memory read per instruction over a valid/ready read channel, and hands the fetched word to decode. It waits for the execute stage to commit before computing the next PC. One instruction is in flight at a time. Fault conditions halt fetch until reset.

## Interface
- BITWIDTH, 32, PC / address / data width
- RST_VALUE, 32'h80000000, PC value loaded by reset

- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous active-low reset; asserted when 0
- araddr  out  BITWIDTH  read address, combinationally equal to pc
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready
- rdata  in  32  read data
- rresp  in  2  read response; 2'b00 = OKAY, anything else = error
- rvalid  in  1  read-data valid
- rready  out  1  read-data ready
- inst  out  32  registered instruction word
- inst_valid  out  1  inst is valid for decode
- inst_ready  in  1  decode accepts inst
- commit_valid  in  1  execute stage finished the current instruction
- pc_sel  in  2  next-PC select: [1] selects adder A (0 = pc, 1 = rs1_data); [0] selects adder B (0 = 4, 1 = imm)
- rs1_data  in  BITWIDTH  register operand for JALR
- imm  in  32  branch / jump immediate
- pc  out  BITWIDTH  PC of the current instruction
- fetch_err  out  1  sticky fault flag
- err_cause  out  2  01 = bus error, 10 = misaligned next PC, 00 = none
- retired  out  32  count of committed instructions

## Operation
- States: IDLE, AR, R, ISSUE, EXEC, ERROR.
- **IDLE**: entered on reset; lasts exactly one cycle, then goes to AR.
- **AR**: arvalid=1. On arvalid&&arready, go to R.
  - araddr must be stable while arvalid=1 and arready=0.
- **R**: rready=1. On rvalid:
  - rresp==00: inst<=rdata, go to ISSUE.
  - otherwise: go to ERROR with err_cause=01.
- **ISSUE**: inst_valid=1. On inst_ready, go to EXEC.
- **EXEC**: on commit_valid:
  - retired<=retired+1, wrapping at 2^32.
  - next = A + B, truncated to BITWIDTH.
  - If pc_sel==11 (JALR), bit 0 of next is forced to 0.
  - If next[1:0]!=00: go to ERROR with err_cause=10; pc is unchanged.
  - Otherwise: pc<=next and go to AR.
- **ERROR**: fetch_err=1, all valids 0. Leave only via reset.
- commit_valid outside EXEC is ignored.
- rvalid outside R is ignored (rready=0).
- inst_ready outside ISSUE is ignored.
- Reset values:
  - pc=RST_VALUE, inst=0, retired=0, fetch_err=0, err_cause=00.
  - arvalid=0, rready=0, inst_valid=0.
- arvalid, rready and inst_valid are decoded from registered state; they are not combinational from inputs.

## Timing
- First arvalid appears on the 2nd rising edge after rst returns to 1 (IDLE then AR).
- With arready, rvalid and inst_ready held at 1 and commit in the same cycle:
  - AR 1 cycle, R 1 cycle, ISSUE 1 cycle, EXEC 1 cycle.
  - Throughput is 4 cycles per instruction.
- The new pc is visible the cycle after commit, together with arvalid=1.
- arready and rvalid are sampled at the clock edge. Zero-cycle wait is legal on both.
- A handshake that occurs in the same cycle as the first valid cycle counts.
- rst=0 in any state: the next edge forces IDLE with all reset values, dropping any outstanding transaction. The memory slave shares the same reset.
- Simultaneous rst=0 and commit_valid: reset wins; pc=RST_VALUE and retired=0.

## Test plan
- **Reset fetch**: release rst, arready=rvalid=1, rdata=32'h00000013.
  - araddr=32'h80000000 with arvalid at cycle 2; inst=32'h00000013, inst_valid at cycle 4.
- **Sequential and branch commits**:
  - Commit with pc_sel=00: pc=32'h80000004, retired=1.
  - Then pc_sel=01, imm=32'hFFFFFFFC: pc=32'h80000000, retired=2.
- **JALR and misalignment**:
  - pc_sel=11, rs1_data=32'h80001001, imm=0: pc=32'h80001000.
  - rs1_data=32'h80001002: fetch_err=1, err_cause=10, pc unchanged, no further arvalid.
- **Stalls**:
  - arready low 3 cycles: araddr and arvalid stable throughout.
  - rvalid delayed 5 cycles: rready stays 1.
  - inst_ready low 2 cycles: inst and inst_valid stable.
- **Bus error**: rresp=2'b10.
  - fetch_err=1, err_cause=01, inst unchanged.
  - Stuck until rst=0, then restarts at 32'h80000000.
- **Reset mid-operation and stray inputs**:
  - Assert rst in R: next cycle rready=0 and state is IDLE.
  - commit_valid pulsed in AR: pc and retired unchanged.
